// File: rtl/ysyx_041514_alu_mdu_ctrl.sv
// Sequences MUL/DIV ops between EX and the ALU: buffers results when EX is stalled and drains flushed ops.
// Latency: outputs are registered or decoded from registered state; capture is visible one cycle after the ready pulse.
module ysyx_041514_alu_mdu_ctrl #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid_i,
    input  logic             mdu_op_i,
    input  logic             alu_data_ready_i,
    input  logic [XLEN-1:0]  alu_out_i,
    input  logic             ex_advance_i,
    input  logic             flush_i,
    output logic             buff_valid_o,
    output logic [XLEN-1:0]  buff_data_o,
    output logic             issue_block_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] perf_cycles_o,
    output logic [CNT_W-1:0] perf_ops_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic credit;
    logic capture;

    // A result only counts when it lands for an instruction that was not flushed.
    assign credit  = (state == S_WAIT) && alu_data_ready_i && !flush_i;
    assign capture = credit && !ex_advance_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (ex_valid_i && mdu_op_i) begin
                    state_nxt = flush_i ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush_i && alu_data_ready_i) begin
                    state_nxt = S_IDLE;
                end else if (flush_i) begin
                    state_nxt = S_DRAIN;
                end else if (alu_data_ready_i) begin
                    state_nxt = ex_advance_i ? S_IDLE : S_HOLD;
                end
            end
            S_HOLD: begin
                if (flush_i || ex_advance_i) begin
                    state_nxt = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (alu_data_ready_i) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        buff_valid_o  = (state == S_HOLD);
        issue_block_o = (state == S_DRAIN);
        busy_o        = (state != S_IDLE);
    end

    // Buffer keeps its last capture after release; only a new capture or reset changes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buff_data_o <= '0;
        end else if (capture) begin
            buff_data_o <= alu_out_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles_o <= '0;
            perf_ops_o    <= '0;
        end else begin
            if (((state == S_WAIT) || (state == S_DRAIN)) && (perf_cycles_o != '1)) begin
                perf_cycles_o <= perf_cycles_o + 1'b1;
            end
            if (credit && (perf_ops_o != '1)) begin
                perf_ops_o <= perf_ops_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_041514_alu_mdu_ctrl.sv
// Bench for ysyx_041514_alu_mdu_ctrl: directed scenarios, an op-tracking reference model
// compared every cycle, plus literal checks at the interesting points of each scenario.
module tb_ysyx_041514_alu_mdu_ctrl;

    localparam int XLEN = 64;
    localparam int CW   = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ex_valid = 1'b0;
    logic            mdu_op = 1'b0;
    logic            alu_ready = 1'b0;
    logic [XLEN-1:0] alu_out = '0;
    logic            ex_advance = 1'b0;
    logic            flush = 1'b0;
    logic            buff_valid;
    logic [XLEN-1:0] buff_data;
    logic            issue_block;
    logic            busy;
    logic [CW-1:0]   perf_cycles;
    logic [CW-1:0]   perf_ops;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    ysyx_041514_alu_mdu_ctrl #(.XLEN(XLEN), .CNT_W(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .ex_valid_i       (ex_valid),
        .mdu_op_i         (mdu_op),
        .alu_data_ready_i (alu_ready),
        .alu_out_i        (alu_out),
        .ex_advance_i     (ex_advance),
        .flush_i          (flush),
        .buff_valid_o     (buff_valid),
        .buff_data_o      (buff_data),
        .issue_block_o    (issue_block),
        .busy_o           (busy),
        .perf_cycles_o    (perf_cycles),
        .perf_ops_o       (perf_ops)
    );

    always #5 clk = ~clk;

    // Model: which op (if any) is live and whether it still owes a result to EX.
    typedef struct packed {
        logic            live_op;
        logic            dead_op;
        logic            held;
        logic [XLEN-1:0] data;
        logic [CW-1:0]   cyc;
        logic [CW-1:0]   ops;
    } model_t;

    model_t m;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] x);
        return (x == {CW{1'b1}}) ? x : x + 1'b1;
    endfunction

    function automatic model_t model_next(input model_t c, input logic ev, input logic op,
                                          input logic rdy, input logic [XLEN-1:0] d,
                                          input logic adv, input logic fl);
        model_t n;
        n = c;
        if (c.live_op || c.dead_op) n.cyc = sat_inc(c.cyc);
        if (c.held) begin
            if (fl || adv) n.held = 1'b0;
        end else if (c.live_op) begin
            if (fl) begin
                n.live_op = 1'b0;
                n.dead_op = !rdy;
            end else if (rdy) begin
                n.live_op = 1'b0;
                n.ops     = sat_inc(c.ops);
                if (!adv) begin
                    n.held = 1'b1;
                    n.data = d;
                end
            end
        end else if (c.dead_op) begin
            if (rdy) n.dead_op = 1'b0;
        end else if (ev && op) begin
            n.live_op = !fl;
            n.dead_op = fl;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= '0;
        else     m <= model_next(m, ex_valid, mdu_op, alu_ready, alu_out, ex_advance, flush);
    end

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_busy",   XLEN'(busy),        XLEN'(m.live_op | m.dead_op | m.held));
            chk("m_valid",  XLEN'(buff_valid),  XLEN'(m.held));
            chk("m_block",  XLEN'(issue_block), XLEN'(m.dead_op));
            chk("m_data",   buff_data,          m.data);
            chk("m_cycles", XLEN'(perf_cycles), XLEN'(m.cyc));
            chk("m_ops",    XLEN'(perf_ops),    XLEN'(m.ops));
            if (m.live_op && ex_advance && !alu_ready && !flush) begin
                errors++;
                $display("FAIL protocol: ex_advance while op outstanding at %0t", $time);
            end
        end
    end

    task automatic step(input logic ev, input logic op, input logic rdy,
                        input logic [XLEN-1:0] d, input logic adv, input logic fl);
        ex_valid = ev; mdu_op = op; alu_ready = rdy; alu_out = d; ex_advance = adv; flush = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, 0);
    endtask

    task automatic do_reset();
        ex_valid = 0; mdu_op = 0; alu_ready = 0; alu_out = '0; ex_advance = 0; flush = 0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"},  XLEN'(buff_valid),  '0);
        chk({tag, "_data"},   buff_data,          '0);
        chk({tag, "_block"},  XLEN'(issue_block), '0);
        chk({tag, "_busy"},   XLEN'(busy),        '0);
        chk({tag, "_cycles"}, XLEN'(perf_cycles), '0);
        chk({tag, "_ops"},    XLEN'(perf_ops),    '0);
    endtask

    initial begin
        do_reset();
        chk_all_zero("rst");

        // Unstalled MUL: result consumed straight from the ALU.
        step(1, 1, 0, '0, 0, 0);
        chk("s1_busy", XLEN'(busy), 1);
        for (int i = 1; i < 4; i++) step(1, 1, 0, '0, 0, 0);
        step(1, 1, 1, 64'h1234, 1, 0);
        chk("s1_busy_after", XLEN'(busy), 0);
        chk("s1_valid", XLEN'(buff_valid), 0);
        chk("s1_ops", XLEN'(perf_ops), 1);
        chk("s1_cycles", XLEN'(perf_cycles), 4);
        idle(2);

        // Downstream stall: result captured and held until EX advances.
        do_reset();
        step(1, 1, 0, '0, 0, 0);
        for (int i = 1; i < 4; i++) step(1, 1, 0, '0, 0, 0);
        step(1, 1, 1, 64'hDEADBEEF00000001, 0, 0);
        chk("s2_valid5", XLEN'(buff_valid), 1);
        chk("s2_data5", buff_data, 64'hDEADBEEF00000001);
        step(1, 1, 0, 64'h5555, 0, 0);
        step(1, 1, 0, 64'h6666, 0, 0);
        chk("s2_valid7", XLEN'(buff_valid), 1);
        chk("s2_data7", buff_data, 64'hDEADBEEF00000001);
        step(1, 1, 0, 64'h7777, 1, 0);
        chk("s2_valid8", XLEN'(buff_valid), 0);
        chk("s2_keep", buff_data, 64'hDEADBEEF00000001);
        chk("s2_ops", XLEN'(perf_ops), 1);
        idle(2);

        // Flush mid-DIV: killed op drained, never credited.
        do_reset();
        step(1, 1, 0, '0, 0, 0);
        step(1, 1, 0, '0, 0, 0);
        step(1, 1, 0, '0, 0, 1);
        chk("s3_block3", XLEN'(issue_block), 1);
        for (int i = 3; i < 10; i++) step(0, 0, 0, '0, 0, 0);
        chk("s3_block10", XLEN'(issue_block), 1);
        step(0, 0, 1, 64'hBAD, 0, 0);
        chk("s3_block11", XLEN'(issue_block), 0);
        chk("s3_valid", XLEN'(buff_valid), 0);
        chk("s3_ops", XLEN'(perf_ops), 0);
        chk("s3_cycles", XLEN'(perf_cycles), 10);
        idle(2);

        // Flush coincident with ready in WAIT.
        do_reset();
        step(1, 1, 0, '0, 0, 0);
        step(1, 1, 0, '0, 0, 0);
        step(1, 1, 1, 64'hAAAA, 0, 1);
        chk("s4_busy", XLEN'(busy), 0);
        chk("s4_block", XLEN'(issue_block), 0);
        chk("s4_valid", XLEN'(buff_valid), 0);
        chk("s4_ops", XLEN'(perf_ops), 0);
        idle(2);

        // Flush together with advance while holding; then a back-to-back op.
        do_reset();
        step(1, 1, 0, '0, 0, 0);
        step(1, 1, 1, 64'hC0FFEE, 0, 0);
        chk("s5_valid", XLEN'(buff_valid), 1);
        step(0, 0, 0, '0, 1, 1);
        chk("s5_valid_off", XLEN'(buff_valid), 0);
        chk("s5_busy", XLEN'(busy), 0);
        chk("s5_ops", XLEN'(perf_ops), 1);
        step(1, 1, 0, '0, 0, 0);
        chk("s6_b2b_busy", XLEN'(busy), 1);
        step(1, 1, 1, 64'h42, 1, 0);
        chk("s6_ops", XLEN'(perf_ops), 2);
        idle(2);

        // Asynchronous reset while holding a result.
        do_reset();
        step(1, 1, 0, '0, 0, 0);
        step(1, 1, 1, 64'hFACE, 0, 0);
        chk("s7_valid", XLEN'(buff_valid), 1);
        #2 rst = 1'b1;
        #1 chk_all_zero("arst");
        #2 rst = 1'b0;
        step(1, 1, 0, '0, 0, 0);
        step(1, 1, 1, 64'h99, 1, 0);
        chk("s7_ops", XLEN'(perf_ops), 1);
        chk("s7_cycles", XLEN'(perf_cycles), 1);
        idle(2);

        // Counter saturation (4-bit counters in this bench).
        do_reset();
        step(1, 1, 0, '0, 0, 0);
        for (int i = 0; i < 17; i++) step(1, 1, 0, '0, 0, 0);
        step(1, 1, 1, 64'h1, 1, 0);
        chk("sat_cycles", XLEN'(perf_cycles), 15);
        for (int i = 0; i < 16; i++) begin
            step(1, 1, 0, '0, 0, 0);
            step(1, 1, 1, XLEN'(i), 1, 0);
        end
        chk("sat_ops", XLEN'(perf_ops), 15);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_041514_alu_mdu_ctrl.md
# ysyx_041514_alu_mdu_ctrl

Sequencing controller for the ALU's multi-cycle multiply/divide unit (MDU). It sits between the execute stage and the ALU top. It tracks each in-flight MUL/DIV operation and captures the single-cycle result pulse into the ALU result buffer when the pipeline cannot advance. It also drains operations killed by a flush, so that a stale ready pulse is never credited to a younger instruction. It additionally provides MDU busy-cycle and completed-op performance counters.

## Interface
Parameters:
- XLEN, 64, datapath width
- CNT_W, 32, performance counter width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- ex_valid_i  in  1  EX stage holds a valid instruction
- mdu_op_i  in  1  EX op is any MUL*/DIV*/REM* ALU op
- alu_data_ready_i  in  1  one-cycle MDU result pulse from ALU (mul ready | div ready)
- alu_out_i  in  XLEN  ALU result; valid for MDU ops only in the ready cycle
- ex_advance_i  in  1  instruction leaves EX this cycle
- flush_i  in  1  pipeline flush (trap/redirect), kills EX instruction
- buff_valid_o  out  1  drives ALU result-buffer valid
- buff_data_o  out  XLEN  drives ALU result-buffer data
- issue_block_o  out  1  EX must not present a new MDU op (drain in progress)
- busy_o  out  1  state != IDLE
- perf_cycles_o  out  CNT_W  cycles spent in WAIT or DRAIN, saturating
- perf_ops_o  out  CNT_W  MDU ops completed for non-flushed instructions, saturating

## Operation
- States: IDLE, WAIT (op in flight), HOLD (result buffered), DRAIN (killed op in flight). 2-bit encoded and registered.
- IDLE:
  - ex_valid_i & mdu_op_i & flush_i -> DRAIN. The ALU launches the request combinationally, so the op must be drained.
  - ex_valid_i & mdu_op_i & ~flush_i -> WAIT.
  - alu_data_ready_i in IDLE is ignored.
- WAIT: evaluated in priority order.
  - flush_i & alu_data_ready_i -> IDLE, result discarded.
  - flush_i -> DRAIN.
  - alu_data_ready_i & ex_advance_i -> IDLE. The result is consumed directly from the ALU. perf_ops +1.
  - alu_data_ready_i & ~ex_advance_i -> HOLD. buff_data_o <= alu_out_i. perf_ops +1.
  - Otherwise stay in WAIT.
- HOLD:
  - buff_valid_o = 1, so the ALU selects buff_data_o and drops its stall.
  - flush_i or ex_advance_i -> IDLE, buff_valid_o cleared.
  - buff_data_o holds its value until the next capture. It is not zeroed on leaving HOLD.
- DRAIN:
  - issue_block_o = 1.
  - alu_data_ready_i -> IDLE, result discarded. No perf_ops increment.
  - flush_i in DRAIN has no further effect.
- perf_cycles_o increments on every cycle where the current state is WAIT or DRAIN. It saturates at all-ones.
- perf_ops_o saturates at all-ones.
- ex_advance_i while in WAIT without alu_data_ready_i is a protocol violation, because the ALU stalls EX. The controller ignores it and the bench flags it.

## Timing
- Reset: asynchronous. State, buff_valid_o, buff_data_o and both counters are cleared immediately on rst high.
  - All outputs read 0: buff_valid_o=0, buff_data_o=0, issue_block_o=0, busy_o=0, perf_cycles_o=0, perf_ops_o=0.
  - rst mid-WAIT or mid-DRAIN abandons tracking. The MDU is reset by the same rst.
- All outputs are registered or decoded from the registered state. There is no combinational path from inputs to outputs.
- Capture latency: a ready pulse in cycle T with ex_advance_i low gives buff_valid_o=1 and buff_data_o=alu_out_i(T) from cycle T+1.
- Release: ex_advance_i or flush_i in cycle T while in HOLD gives buff_valid_o=0 from cycle T+1.
- A new MDU op may enter EX in cycle T+1 after release. IDLE accepts it that cycle, so back-to-back MDU ops have no bubble added by this block.
- issue_block_o:
  - Rises the cycle after entry to DRAIN.
  - Falls the cycle after the drain ready pulse.
- busy_o follows state with the same one-cycle registered timing.

## Test plan
- Unstalled MUL:
  - Stimulus: ex_valid_i=mdu_op_i=1 at cycle 0; ready at cycle 4 with ex_advance_i=1.
  - Required: buff_valid_o stays 0; IDLE at cycle 5; perf_ops_o=1; perf_cycles_o=4.
- Downstream stall:
  - Stimulus: ready at cycle 4 with alu_out_i=0xDEADBEEF00000001; ex_advance_i low until cycle 7.
  - Required: buff_valid_o=1 and buff_data_o=0xDEADBEEF00000001 for cycles 5–7; buff_valid_o=0 at cycle 8.
- Flush mid-op:
  - Stimulus: flush_i at cycle 2 of a DIV; ready at cycle 10.
  - Required: DRAIN; issue_block_o=1 for cycles 3–10, 0 at cycle 11; buff_valid_o never 1; perf_ops_o unchanged; perf_cycles_o +10.
- Flush coincident with ready in WAIT:
  - Required: IDLE next cycle; no DRAIN; no capture; perf_ops_o unchanged.
- Flush in HOLD together with ex_advance_i:
  - Required: buff_valid_o=0 next cycle; IDLE; perf_ops_o keeps the increment from capture.
- Async reset mid-HOLD:
  - Stimulus: rst asserted between clock edges.
  - Required: all outputs 0 before the next edge; a MUL issued after reset runs normally.
